// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - wide add sequenced through a 4-bit adder
// Each nibble takes an operand pass then a carry pass, since the adder has no carry-in.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sign,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic [3:0]   flags,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_sign,
  input  logic [3:0]   add_result,
  input  logic [3:0]   add_flags
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, CARRY, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic           a_msb;
  logic           b_msb;
  logic           sign_q;
  logic [IW-1:0]  idx;
  logic           c1;
  logic           cin;
  logic           cout;
  logic [W-1:0]   sum_fin;
  logic           unused_flags;

  assign add_sign     = 1'b0;
  assign unused_flags = ^add_flags[2:0];
  assign cout         = c1 | add_flags[3];

  // sum as it will look once the current carry pass lands; feeds the final flags
  always_comb begin
    sum_fin = sum;
    sum_fin[4*idx +: 4] = add_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      flags  <= '0;
      add_a  <= '0;
      add_b  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sign_q <= 1'b0;
      idx    <= '0;
      c1     <= 1'b0;
      cin    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= op_a >> 4;
            b_sh   <= op_b >> 4;
            add_a  <= op_a[3:0];
            add_b  <= op_b[3:0];
            a_msb  <= op_a[W-1];
            b_msb  <= op_b[W-1];
            sign_q <= sign;
            sum    <= '0;
            cin    <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end else begin
            add_a <= '0;
            add_b <= '0;
            state <= IDLE;
          end
        end
        ADD: begin
          c1    <= add_flags[3];
          add_a <= add_result;
          add_b <= {3'b000, cin};
          state <= CARRY;
        end
        CARRY: begin
          sum[4*idx +: 4] <= add_result;
          cin <= cout;
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            add_a <= '0;
            add_b <= '0;
            flags <= {cout,
                      sum_fin == '0,
                      sign_q & sum_fin[W-1],
                      sign_q & (a_msb == b_msb) & (sum_fin[W-1] != a_msb)};
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            add_a <= a_sh[3:0];
            add_b <= b_sh[3:0];
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            state <= ADD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - scoreboard bench for nibble_add_sequencer
// A behavioural 4-bit adder sits on the add_* ports; results come from a wide reference add.
module tb_nibble_add_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic [3:0]  flags;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_sign;
  logic [3:0]  add_result;
  logic [3:0]  add_flags;
  logic [4:0]  s5;

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] sb[$];
  logic [19:0] last_exp = '0;

  nibble_add_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .sum(sum), .flags(flags), .add_a(add_a), .add_b(add_b),
    .add_sign(add_sign), .add_result(add_result), .add_flags(add_flags)
  );

  always #5 clk = ~clk;

  assign s5         = {1'b0, add_a} + {1'b0, add_b};
  assign add_result = s5[3:0];
  assign add_flags  = {s5[4], s5[3:0] == 4'h0, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] t;
    logic [15:0] r;
    t = {1'b0, a} + {1'b0, b};
    r = t[15:0];
    return {r, t[16], r == 16'h0, s & r[15], s & (a[15] == b[15]) & (r[15] != a[15])};
  endfunction

  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("sum", sum, e[19:4]);
        check("flags", flags, e[3:0]);
      end
    end
  end

  // call at posedge+2 while idle; returns at posedge+2 of cycle 1
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    start = 1'b1; op_a = a; op_b = b; sign = s;
    last_exp = model(a, b, s);
    sb.push_back(last_exp);
    @(posedge clk); #2;
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); sign = 1'($urandom);
  endtask

  task automatic track(input bit ripple, input bit glitch, input bit chain,
                       input logic [15:0] ca, input logic [15:0] cb, input logic cs);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("busy", busy, k <= 8);
      check("done", done, k == 9);
      if (ripple && (k % 2 == 0))
        check("carry_pass_b", add_b, (k >= 4) ? 1 : 0);
      if (glitch && k == 2) begin
        @(posedge clk); #2;
        start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
      end
      if (glitch && k == 3) begin
        @(posedge clk); #2;
        start = 1'b0;
      end
      if (chain && k == 8) begin
        @(posedge clk); #2;
        start = 1'b1; op_a = ca; op_b = cb; sign = cs;
        last_exp = model(ca, cb, cs);
        sb.push_back(last_exp);
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
    if (!chain) begin
      check("idle_done", done, 0);
      check("idle_add_ab", {add_a, add_b}, 0);
      check("sum_hold", sum, last_exp[19:4]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", flags, 0);
    check("rst_add_ab", {add_a, add_b}, 0);
    check("add_sign", add_sign, 0);
    reset = 1'b0;
    @(posedge clk); #2;

    launch(16'h1234, 16'h1111, 1'b0);
    track(0, 1, 0, '0, '0, 0);
    launch(16'h0FFF, 16'h0001, 1'b0);
    track(1, 0, 0, '0, '0, 0);
    launch(16'hFFFF, 16'h0001, 1'b0);
    track(0, 0, 0, '0, '0, 0);
    launch(16'h7FFF, 16'h0001, 1'b1);
    track(0, 0, 0, '0, '0, 0);
    launch(16'h8000, 16'h8000, 1'b1);
    track(0, 0, 1, 16'h0001, 16'h0001, 1'b0);
    track(0, 0, 0, '0, '0, 0);

    // start ignored mid-operation, then async reset discards the operation
    launch(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #3;
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_sum", sum, 0);
    check("async_flags", flags, 0);
    check("async_add_ab", {add_a, add_b}, 0);
    sb.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
    end
    @(posedge clk); #2;
    launch(16'hA5C3, 16'h5A3D, 1'b1);
    track(0, 0, 0, '0, '0, 0);

    for (int n = 0; n < 6; n++) begin
      launch(16'($urandom), 16'($urandom), 1'($urandom));
      track(0, 0, 0, '0, '0, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
